// File: rtl/smac_wb_out_buffer.sv
// smac_wb_out_buffer: output stage behind Data_Path_1x64.
// Captures out_data on each wb strobe into a DEPTH-entry FIFO and drains it to the
// output-feature-map memory over a valid/ready port with auto-incrementing word addresses.
// core_stall_n back-pressures CTRL_unit when the FIFO nears full.
// Optional build macro: WB_OVF_CNT_EN (sticky ovf flag plus a 16-bit saturating drop_cnt).
module smac_wb_out_buffer #(
    parameter int BW    = 128,
    parameter int DEPTH = 8,
    parameter int AW    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       flush,
    input  logic [AW-1:0]              base_addr,
    input  logic                       wb,
    input  logic [BW-1:0]              out_data,
    output logic                       core_stall_n,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic [AW-1:0]              mem_addr,
    output logic [BW-1:0]              mem_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       done,
    output logic                       ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_t;

    state_t          state_r;
    logic [BW-1:0]   fifo_mem [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [LW-1:0]   level_r;
    logic            mem_valid_r;
    logic [AW-1:0]   mem_addr_r;
    logic [BW-1:0]   mem_data_r;
    logic            core_stall_n_r;
    logic            done_r;

    logic            start_s;
    logic            active_s;
    logic            full_s;
    logic            pop_s;
    logic            push_s;
    logic            drop_s;
    logic [LW-1:0]   level_nxt_s;
    logic [PW-1:0]   rd_ptr_nxt_s;
    logic [BW-1:0]   head_nxt_s;

    assign start_s  = start && (state_r == ST_IDLE);
    assign active_s = (state_r != ST_IDLE);
    assign full_s   = (level_r == LW'(DEPTH));
    assign pop_s    = mem_valid_r && mem_ready;
    assign push_s   = wb && active_s && (!full_s || pop_s);
    assign drop_s   = wb && active_s && full_s && !pop_s;

    // Next occupancy and read pointer, shared by stall, valid and head prefetch.
    always_comb begin
        level_nxt_s  = level_r;
        rd_ptr_nxt_s = rd_ptr_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LW'(1);
            2'b01:   level_nxt_s = level_r - LW'(1);
            default: level_nxt_s = level_r;
        endcase
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PW'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

    // Next head word; bypasses the incoming word when it becomes the head this edge.
    always_comb begin
        head_nxt_s = mem_data_r;
        if (level_nxt_s == {LW{1'b0}}) begin
            head_nxt_s = mem_data_r;
        end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = out_data;
        end else begin
            head_nxt_s = fifo_mem[rd_ptr_nxt_s];
        end
    end

    // FIFO storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem[wr_ptr_r] <= out_data;
        end
    end

    // Control FSM with the registered done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (level_nxt_s == {LW{1'b0}}) begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // FIFO pointers, occupancy and the registered memory-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r       <= {PW{1'b0}};
            rd_ptr_r       <= {PW{1'b0}};
            level_r        <= {LW{1'b0}};
            mem_valid_r    <= 1'b0;
            mem_addr_r     <= {AW{1'b0}};
            mem_data_r     <= {BW{1'b0}};
            core_stall_n_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            rd_ptr_r       <= rd_ptr_nxt_s;
            level_r        <= level_nxt_s;
            mem_valid_r    <= (level_nxt_s != {LW{1'b0}});
            mem_data_r     <= head_nxt_s;
            core_stall_n_r <= !(level_nxt_s >= LW'(DEPTH - 2));
            if (start_s) begin
                mem_addr_r <= base_addr;
            end else if (pop_s) begin
                mem_addr_r <= mem_addr_r + AW'(1);
            end
        end
    end

`ifdef WB_OVF_CNT_EN
    logic        ovf_r;
    logic [15:0] drop_cnt;

    // Sticky overflow flag (cleared by start) and saturating count of dropped words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r    <= 1'b0;
            drop_cnt <= 16'h0000;
        end else begin
            if (start_s) begin
                ovf_r <= 1'b0;
            end else if (drop_s) begin
                ovf_r <= 1'b1;
            end
            if (drop_s && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'h0001;
            end
        end
    end

    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

    assign core_stall_n = core_stall_n_r;
    assign mem_valid    = mem_valid_r;
    assign mem_addr     = mem_addr_r;
    assign mem_data     = mem_data_r;
    assign level        = level_r;
    assign done         = done_r;

endmodule

// File: tb/tb_smac_wb_out_buffer.sv
// Directed bench for smac_wb_out_buffer (BW=128, DEPTH=8, AW=16).
module tb_smac_wb_out_buffer;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         flush;
    logic [15:0]  base_addr;
    logic         wb;
    logic [127:0] out_data;
    logic         core_stall_n;
    logic         mem_valid;
    logic         mem_ready;
    logic [15:0]  mem_addr;
    logic [127:0] mem_data;
    logic [3:0]   level;
    logic         done;
    logic         ovf;

    int tests_run    = 0;
    int tests_failed = 0;

    smac_wb_out_buffer #(.BW(128), .DEPTH(8), .AW(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .base_addr(base_addr),
        .wb(wb), .out_data(out_data), .core_stall_n(core_stall_n), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data), .level(level),
        .done(done), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tests_run++; if (level !== 4'd0) begin tests_failed++; $display("FAIL reset_level got %0d exp 0", level); end
        tests_run++; if (mem_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b exp 0", mem_valid); end
        tests_run++; if (mem_addr !== 16'h0000) begin tests_failed++; $display("FAIL reset_addr got %h exp 0000", mem_addr); end
        tests_run++; if (mem_data !== 128'h0) begin tests_failed++; $display("FAIL reset_data got %h exp 0", mem_data); end
        tests_run++; if (core_stall_n !== 1'b1) begin tests_failed++; $display("FAIL reset_stall_n got %b exp 1", core_stall_n); end
        tests_run++; if (done !== 1'b0 || ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_done_ovf got %b%b exp 00", done, ovf); end
    endtask

    task automatic test_basic();
        base_addr = 16'h0100; start = 1'b1; tick(); start = 1'b0;
        tests_run++; if (mem_addr !== 16'h0100) begin tests_failed++; $display("FAIL basic_start_addr got %h exp 0100", mem_addr); end
        tests_run++; if (mem_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_idle_valid got %b exp 0", mem_valid); end
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wb = 1'b1; out_data = 128'(i + 1); tick();
            tests_run++; if (mem_valid !== 1'b1 || mem_data !== 128'(i + 1)) begin tests_failed++; $display("FAIL basic_data%0d got v=%b %h exp v=1 %0d", i, mem_valid, mem_data, i + 1); end
            tests_run++; if (mem_addr !== 16'h0100 + 16'(i)) begin tests_failed++; $display("FAIL basic_addr%0d got %h exp %h", i, mem_addr, 16'h0100 + 16'(i)); end
        end
        wb = 1'b0; tick();
        tests_run++; if (mem_valid !== 1'b0 || level !== 4'd0 || mem_addr !== 16'h0104) begin tests_failed++; $display("FAIL basic_end got v=%b l=%0d a=%h exp v=0 l=0 a=0104", mem_valid, level, mem_addr); end
    endtask

    task automatic test_back_pressure();
        mem_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wb = 1'b1; out_data = 128'(16 + i); tick();
            tests_run++; if (level !== 4'(i + 1)) begin tests_failed++; $display("FAIL bp_level%0d got %0d exp %0d", i, level, i + 1); end
            tests_run++; if (core_stall_n !== ((i + 1) >= 6 ? 1'b0 : 1'b1)) begin tests_failed++; $display("FAIL bp_stall%0d got %b at level %0d", i, core_stall_n, i + 1); end
            tests_run++; if (mem_data !== 128'h10 || mem_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_head%0d got %h exp 10", i, mem_data); end
        end
        wb = 1'b0;
    endtask

    task automatic test_full_push_pop();
        wb = 1'b1; out_data = 128'h20; mem_ready = 1'b1; tick();
        wb = 1'b0; mem_ready = 1'b0;
        tests_run++; if (level !== 4'd8) begin tests_failed++; $display("FAIL fpp_level got %0d exp 8", level); end
        tests_run++; if (mem_data !== 128'h11 || mem_addr !== 16'h0105) begin tests_failed++; $display("FAIL fpp_head got %h@%h exp 11@0105", mem_data, mem_addr); end
        tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL fpp_ovf got %b exp 0", ovf); end
    endtask

    task automatic test_overflow();
        logic [127:0] exp_q [8];
        wb = 1'b1; out_data = 128'hFF; tick(); wb = 1'b0;
        tests_run++; if (level !== 4'd8 || mem_data !== 128'h11) begin tests_failed++; $display("FAIL ovf_level got %0d head %h exp 8 head 11", level, mem_data); end
`ifdef WB_OVF_CNT_EN
        tests_run++; if (ovf !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag got %b exp 1", ovf); end
        tests_run++; if (dut.drop_cnt !== 16'd1) begin tests_failed++; $display("FAIL ovf_drop_cnt got %0d exp 1", dut.drop_cnt); end
`else
        tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL ovf_flag got %b exp 0", ovf); end
`endif
        for (int k = 0; k < 7; k++) exp_q[k] = 128'(17 + k);
        exp_q[7] = 128'h20;
        mem_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tests_run++; if (mem_data !== exp_q[k] || mem_addr !== 16'h0105 + 16'(k)) begin tests_failed++; $display("FAIL drain_word%0d got %h@%h exp %h@%h", k, mem_data, mem_addr, exp_q[k], 16'h0105 + 16'(k)); end
            tick();
        end
        mem_ready = 1'b0;
        tests_run++; if (level !== 4'd0 || mem_valid !== 1'b0 || core_stall_n !== 1'b1) begin tests_failed++; $display("FAIL drain_end got l=%0d v=%b s=%b exp 0 0 1", level, mem_valid, core_stall_n); end
        flush = 1'b1; tick(); flush = 1'b0;
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL flush_done_early got %b exp 0", done); end
        tick();
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL flush_done got %b exp 1", done); end
        tick();
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL flush_done_pulse got %b exp 0", done); end
    endtask

    task automatic test_wrap_drain();
        base_addr = 16'hFFFE; start = 1'b1; tick(); start = 1'b0;
        tests_run++; if (mem_addr !== 16'hFFFE || ovf !== 1'b0) begin tests_failed++; $display("FAIL wrap_start got %h ovf=%b exp FFFE ovf=0", mem_addr, ovf); end
        for (int i = 0; i < 3; i++) begin
            wb = 1'b1; out_data = 128'(32'hA1 + i); tick();
        end
        wb = 1'b0; flush = 1'b1; tick(); flush = 1'b0;
        tests_run++; if (done !== 1'b0 || level !== 4'd3) begin tests_failed++; $display("FAIL wrap_flush got done=%b l=%0d exp 0 3", done, level); end
        mem_ready = 1'b1;
        tests_run++; if (mem_addr !== 16'hFFFE || mem_data !== 128'hA1) begin tests_failed++; $display("FAIL wrap_w0 got %h@%h exp A1@FFFE", mem_data, mem_addr); end
        tick();
        tests_run++; if (mem_addr !== 16'hFFFF || mem_data !== 128'hA2 || done !== 1'b0) begin tests_failed++; $display("FAIL wrap_w1 got %h@%h d=%b exp A2@FFFF d=0", mem_data, mem_addr, done); end
        tick();
        tests_run++; if (mem_addr !== 16'h0000 || mem_data !== 128'hA3 || done !== 1'b0) begin tests_failed++; $display("FAIL wrap_w2 got %h@%h d=%b exp A3@0000 d=0", mem_data, mem_addr, done); end
        tick();
        tests_run++; if (done !== 1'b1 || mem_valid !== 1'b0 || mem_addr !== 16'h0001) begin tests_failed++; $display("FAIL wrap_done got d=%b v=%b a=%h exp 1 0 0001", done, mem_valid, mem_addr); end
        mem_ready = 1'b0; tick();
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL wrap_done_pulse got %b exp 0", done); end
        wb = 1'b1; out_data = 128'h55; tick(); wb = 1'b0;
        tests_run++; if (level !== 4'd0 || mem_valid !== 1'b0) begin tests_failed++; $display("FAIL idle_wb got l=%0d v=%b exp 0 0", level, mem_valid); end
    endtask

    task automatic test_reset_mid_op();
        base_addr = 16'h0040; start = 1'b1; flush = 1'b1; tick(); start = 1'b0; flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wb = 1'b1; out_data = 128'(64 + i); tick();
        end
        wb = 1'b0;
        tests_run++; if (level !== 4'd5 || mem_valid !== 1'b1 || mem_data !== 128'h40) begin tests_failed++; $display("FAIL mid_pre got l=%0d v=%b %h exp 5 1 40", level, mem_valid, mem_data); end
        #1 rst_n = 1'b0;
        #1;
        tests_run++; if (level !== 4'd0 || mem_valid !== 1'b0 || mem_addr !== 16'h0000 || mem_data !== 128'h0) begin tests_failed++; $display("FAIL mid_async got l=%0d v=%b a=%h d=%h exp all 0", level, mem_valid, mem_addr, mem_data); end
        tests_run++; if (core_stall_n !== 1'b1 || done !== 1'b0 || ovf !== 1'b0) begin tests_failed++; $display("FAIL mid_async_flags got s=%b d=%b o=%b exp 1 0 0", core_stall_n, done, ovf); end
        #3 rst_n = 1'b1;
        wb = 1'b1; out_data = 128'h77; tick(); wb = 1'b0;
        tests_run++; if (level !== 4'd0 || mem_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_wb_ignored got l=%0d v=%b exp 0 0", level, mem_valid); end
        base_addr = 16'h0200; start = 1'b1; tick(); start = 1'b0;
        wb = 1'b1; out_data = 128'h88; tick(); wb = 1'b0;
        tests_run++; if (level !== 4'd1 || mem_data !== 128'h88 || mem_addr !== 16'h0200) begin tests_failed++; $display("FAIL mid_restart got l=%0d %h@%h exp 1 88@0200", level, mem_data, mem_addr); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; base_addr = 16'h0000;
        wb = 1'b0; out_data = 128'h0; mem_ready = 1'b0;
        #12;
        test_reset();
        #10 rst_n = 1'b1;
        tick();
        test_reset();
        test_basic();
        test_back_pressure();
        test_full_push_pop();
        test_overflow();
        test_wrap_drain();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
